// File: rtl/jump_target_table.sv
// Writable multi-bank jump-target table with a registered lookup path (1-cycle latency).
// Define LINK_STACK_EN to add the call/return link stack (PushReq/PopReq/StackOvf).

module jtt_bank #(
  parameter int PTR_W  = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              we,
  input  logic [PTR_W-1:0]  wptr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [PTR_W-1:0]  rptr,
  output logic [ADDR_W-1:0] rdata,
  output logic              rvld
);
  localparam int ENTRIES = 2**PTR_W;

  logic [ENTRIES-1:0][ADDR_W-1:0] mem;
  logic [ENTRIES-1:0]             vld;

  // Clear applies before the write so a same-cycle write leaves its entry valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
    end else begin
      if (clr) vld <= '0;
      if (we) begin
        mem[wptr] <= wdata;
        vld[wptr] <= 1'b1;
      end
    end
  end

  assign rdata = mem[rptr];
  assign rvld  = vld[rptr];
endmodule

module jump_target_table #(
  parameter int PTR_W       = 4,
  parameter int ADDR_W      = 10,
  parameter int NUM_PROGS   = 3,
  parameter int PROG_W      = 2,
  parameter int STACK_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [PROG_W-1:0] ProgSel,
  input  logic              ProgSelWr,
  input  logic              LookupReq,
  input  logic [PTR_W-1:0]  LutPointer,
  input  logic              WrEn,
  input  logic [PROG_W-1:0] WrProg,
  input  logic [PTR_W-1:0]  WrPtr,
  input  logic [ADDR_W-1:0] WrData,
  input  logic              ClrBank,
`ifdef LINK_STACK_EN
  input  logic              PushReq,
  input  logic [ADDR_W-1:0] PushAddr,
  input  logic              PopReq,
  output logic              StackOvf,
`endif
  output logic [ADDR_W-1:0] absaddress,
  output logic              AddrValid,
  output logic              Miss,
  output logic [PROG_W-1:0] ActiveProg
);
  localparam logic [PROG_W:0] NPROGS = NUM_PROGS[PROG_W:0];

  logic [NUM_PROGS-1:0][ADDR_W-1:0] bank_rd;
  logic [NUM_PROGS-1:0]             bank_rv;

  logic              wr_ok, sel_ok;
  logic              clr_act, byp;
  logic [ADDR_W-1:0] lk_data;
  logic              lk_hit;
  logic              req_vld;
  logic [ADDR_W-1:0] rsp_data;
  logic              rsp_miss;

  assign wr_ok  = ({1'b0, WrProg} < NPROGS);
  assign sel_ok = ({1'b0, ProgSel} < NPROGS);

  for (genvar b = 0; b < NUM_PROGS; b++) begin : g_bank
    jtt_bank #(.PTR_W(PTR_W), .ADDR_W(ADDR_W)) u_bank (
      .clk   (Clk),
      .reset (Reset),
      .clr   (ClrBank && (WrProg == PROG_W'(b))),
      .we    (WrEn && (WrProg == PROG_W'(b))),
      .wptr  (WrPtr),
      .wdata (WrData),
      .rptr  (LutPointer),
      .rdata (bank_rd[b]),
      .rvld  (bank_rv[b])
    );
  end

  // ActiveProg never holds an out-of-range bank, so it also qualifies the write bypass.
  assign clr_act = ClrBank && (WrProg == ActiveProg);
  assign byp     = WrEn && wr_ok && (WrProg == ActiveProg) && (WrPtr == LutPointer);

`ifdef LINK_STACK_EN
  localparam int SP_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  logic [STACK_DEPTH-1:0][ADDR_W-1:0] stk;
  logic [SP_W-1:0]                    st_top;
  logic [CNT_W-1:0]                   st_cnt;
  logic [SP_W-1:0]                    top_nxt, top_prv;
  logic                               st_empty, st_full;

  assign st_empty = (st_cnt == '0);
  assign st_full  = (st_cnt == CNT_W'(STACK_DEPTH));
  assign top_nxt  = (st_top == SP_W'(STACK_DEPTH-1)) ? '0 : SP_W'(st_top + 1'b1);
  assign top_prv  = (st_top == '0) ? SP_W'(STACK_DEPTH-1) : SP_W'(st_top - 1'b1);
`endif

  always_comb begin
    lk_data = bank_rd[ActiveProg];
    lk_hit  = bank_rv[ActiveProg];
    if (clr_act) lk_hit = 1'b0;
    if (byp) begin
      lk_data = WrData;
      lk_hit  = 1'b1;
    end
    req_vld  = LookupReq;
    rsp_data = lk_hit ? lk_data : '0;
    rsp_miss = !lk_hit;
`ifdef LINK_STACK_EN
    // A pop owns the response slot; any same-cycle lookup is dropped.
    if (PopReq) begin
      req_vld = 1'b1;
      if (st_empty) begin
        rsp_data = PushReq ? PushAddr : '0;
        rsp_miss = !PushReq;
      end else begin
        rsp_data = stk[st_top];
        rsp_miss = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      absaddress <= '0;
      AddrValid  <= 1'b0;
      Miss       <= 1'b0;
      ActiveProg <= '0;
    end else begin
      AddrValid <= req_vld;
      if (req_vld) begin
        absaddress <= rsp_data;
        Miss       <= rsp_miss;
      end else begin
        Miss <= 1'b0;
      end
      if (ProgSelWr && sel_ok) ActiveProg <= ProgSel;
    end
  end

`ifdef LINK_STACK_EN
  // Circular stack: a push when full overwrites the oldest slot and flags overflow.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      st_top   <= '0;
      st_cnt   <= '0;
      StackOvf <= 1'b0;
    end else if (PopReq) begin
      if (!st_empty) begin
        if (PushReq) begin
          stk[st_top] <= PushAddr;
        end else begin
          st_top <= top_prv;
          st_cnt <= st_cnt - 1'b1;
        end
      end
    end else if (PushReq) begin
      stk[top_nxt] <= PushAddr;
      st_top       <= top_nxt;
      if (st_full) StackOvf <= 1'b1;
      else         st_cnt   <= st_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_jump_target_table.sv
// Scoreboard bench for jump_target_table: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever AddrValid is presented.

module tb_jump_target_table;
  localparam int PTR_W  = 4;
  localparam int ADDR_W = 10;
  localparam int PROG_W = 2;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              miss;
  } rsp_t;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [PROG_W-1:0] ProgSel;
  logic              ProgSelWr;
  logic              LookupReq;
  logic [PTR_W-1:0]  LutPointer;
  logic              WrEn;
  logic [PROG_W-1:0] WrProg;
  logic [PTR_W-1:0]  WrPtr;
  logic [ADDR_W-1:0] WrData;
  logic              ClrBank;
  logic [ADDR_W-1:0] absaddress;
  logic              AddrValid;
  logic              Miss;
  logic [PROG_W-1:0] ActiveProg;
`ifdef LINK_STACK_EN
  logic              PushReq;
  logic [ADDR_W-1:0] PushAddr;
  logic              PopReq;
  logic              StackOvf;
`endif

  rsp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  jump_target_table dut (
    .Clk(Clk), .Reset(Reset), .ProgSel(ProgSel), .ProgSelWr(ProgSelWr),
    .LookupReq(LookupReq), .LutPointer(LutPointer), .WrEn(WrEn), .WrProg(WrProg),
    .WrPtr(WrPtr), .WrData(WrData), .ClrBank(ClrBank),
`ifdef LINK_STACK_EN
    .PushReq(PushReq), .PushAddr(PushAddr), .PopReq(PopReq), .StackOvf(StackOvf),
`endif
    .absaddress(absaddress), .AddrValid(AddrValid), .Miss(Miss), .ActiveProg(ActiveProg)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (AddrValid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid: got addr=%0d miss=%0b, required no response", absaddress, Miss);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        if (absaddress !== e.addr || Miss !== e.miss) begin
          bad++;
          $display("FAIL response: got addr=%0d miss=%0b, required addr=%0d miss=%0b",
                   absaddress, Miss, e.addr, e.miss);
        end
      end
    end else if (AddrValid === 1'b0) begin
      total++;
      if (Miss !== 1'b0) begin
        bad++;
        $display("FAIL idle_miss: got miss=%0b, required 0", Miss);
      end
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    ProgSelWr = 1'b0; LookupReq = 1'b0; WrEn = 1'b0; ClrBank = 1'b0;
`ifdef LINK_STACK_EN
    PushReq = 1'b0; PopReq = 1'b0;
`endif
  endtask

  task automatic expect_rsp(input logic [ADDR_W-1:0] a, input logic m);
    rsp_t e;
    e.addr = a;
    e.miss = m;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic lookup(input int ptr, input int a, input logic m);
    LookupReq = 1'b1;
    LutPointer = PTR_W'(ptr);
    expect_rsp(ADDR_W'(a), m);
  endtask

  task automatic wr(input int prog, input int ptr, input int data);
    WrEn = 1'b1;
    WrProg = PROG_W'(prog);
    WrPtr = PTR_W'(ptr);
    WrData = ADDR_W'(data);
  endtask

  initial begin
    Reset = 1'b1; ProgSel = '0; LutPointer = '0; WrProg = '0; WrPtr = '0; WrData = '0;
`ifdef LINK_STACK_EN
    PushAddr = '0;
`endif
    idle();
    cyc(); cyc();
    chk("reset_addr", int'(absaddress), 0);
    chk("reset_valid", int'(AddrValid), 0);
    chk("reset_miss", int'(Miss), 0);
    chk("reset_prog", int'(ActiveProg), 0);
    Reset = 1'b0;

    // T1: lookup of an empty table misses
    lookup(3, 0, 1'b1); cyc(); idle();

    // T2: writes then back-to-back lookups
    wr(0, 0, 14); cyc();
    wr(0, 9, 110); cyc(); idle();
    lookup(0, 14, 1'b0); cyc();
    lookup(9, 110, 1'b0); cyc(); idle();
    cyc();
    chk("hold_addr", int'(absaddress), 110);
    chk("hold_valid", int'(AddrValid), 0);

    // T3: bank switch; same-cycle lookup still uses the old bank
    wr(1, 2, 500); cyc(); idle();
    ProgSelWr = 1'b1; ProgSel = 2'd1; lookup(2, 0, 1'b1); cyc();
    chk("prog_sel1", int'(ActiveProg), 1);
    ProgSelWr = 1'b0; lookup(2, 500, 1'b0); cyc(); idle();
    ProgSelWr = 1'b1; ProgSel = 2'd0; cyc(); idle();

    // T4: write-first bypass, then clear
    wr(0, 5, 77); lookup(5, 77, 1'b0); cyc(); idle();
    ClrBank = 1'b1; WrProg = 2'd0; lookup(5, 0, 1'b1); cyc(); idle();
    lookup(0, 0, 1'b1); cyc(); idle();
    ClrBank = 1'b1; wr(0, 0, 15); lookup(0, 15, 1'b0); cyc(); idle();
    lookup(0, 15, 1'b0); cyc();
    lookup(9, 0, 1'b1); cyc(); idle();
    wr(3, 1, 99); cyc(); idle();
    lookup(1, 0, 1'b1); cyc(); idle();

    // T5: out-of-range bank select ignored; reset drops a pending lookup
    ProgSelWr = 1'b1; ProgSel = 2'd3; cyc();
    chk("prog_sel3_ignored", int'(ActiveProg), 0);
    ProgSel = 2'd2; cyc();
    chk("prog_sel2", int'(ActiveProg), 2);
    ProgSel = 2'd3; cyc(); idle();
    chk("prog_sel3_keep", int'(ActiveProg), 2);
    Reset = 1'b1; LookupReq = 1'b1; LutPointer = 4'd9; cyc();
    Reset = 1'b0; idle();
    chk("reset_drop_valid", int'(AddrValid), 0);
    chk("reset_prog_again", int'(ActiveProg), 0);
    lookup(9, 0, 1'b1); cyc(); idle();

`ifdef LINK_STACK_EN
    // T6: overflowing pushes, pops, then empty pop
    for (int i = 1; i <= 5; i++) begin
      PushReq = 1'b1; PushAddr = ADDR_W'(i * 10); cyc();
    end
    idle();
    chk("stack_ovf", int'(StackOvf), 1);
    for (int i = 5; i >= 2; i--) begin
      PopReq = 1'b1; expect_rsp(ADDR_W'(i * 10), 1'b0); cyc();
    end
    PopReq = 1'b1; expect_rsp('0, 1'b1); cyc(); idle();
    PopReq = 1'b1; PushReq = 1'b1; PushAddr = 10'd33; expect_rsp(10'd33, 1'b0); cyc(); idle();
    PopReq = 1'b1; expect_rsp('0, 1'b1); cyc(); idle();
`endif

    cyc(); cyc();
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
